// File: rtl/adj_btn_pkg.sv
// Shared types and default timing for the adjust-button conditioner (31.5 MHz clock).
// Auto-repeat is enabled by defining ADJ_AUTOREPEAT_EN.
package adj_btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 315000;    // 10 ms
  localparam int unsigned DEF_REPEAT_DELAY    = 15750000;  // 0.5 s
  localparam int unsigned DEF_REPEAT_PERIOD   = 3150000;   // 100 ms

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned CH_HRS = 0;
  localparam int unsigned CH_MIN = 1;
  localparam int unsigned CH_SEC = 2;

endpackage

// File: rtl/adj_button_conditioner_channel.sv
// One button: 2-FF synchroniser, counter debounce, press/auto-repeat strobe FSM.
// Hold-to-repeat (HELD -> REPEAT) exists only when ADJ_AUTOREPEAT_EN is defined.
module adj_btn_channel
  import adj_btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic pulse,
  output logic level
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES) + 1;

  logic [1:0]      sync_ff;
  logic            sync;
  logic            differ;
  logic            flip;
  logic            level_nxt;
  logic            rise;
  logic [DB_W-1:0] db_cnt;
  state_t          state;
  state_t          state_nxt;
  logic            pulse_nxt;

`ifdef ADJ_AUTOREPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = $clog2(REP_MAX) + 1;
  logic [REP_W-1:0] rep_cnt;
  logic [REP_W-1:0] rep_nxt;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_ff <= '0;
    else          sync_ff <= {sync_ff[0], raw};
  end

  assign sync = sync_ff[1];

  // The FSM looks at the level the debouncer is about to register so the
  // strobe lands on the same edge as the level change.
  always_comb begin
    differ    = (sync != level);
    flip      = differ && (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
    level_nxt = level ^ flip;
    rise      = level_nxt && !level;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_cnt <= '0;
      level  <= 1'b0;
    end else begin
      if (!differ || flip) db_cnt <= '0;
      else                  db_cnt <= db_cnt + DB_W'(1);
      level <= level_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      pulse   <= 1'b0;
`ifdef ADJ_AUTOREPEAT_EN
      rep_cnt <= '0;
`endif
    end else begin
      state   <= state_nxt;
      pulse   <= pulse_nxt;
`ifdef ADJ_AUTOREPEAT_EN
      rep_cnt <= rep_nxt;
`endif
    end
  end

`ifdef ADJ_AUTOREPEAT_EN
  always_comb begin
    state_nxt = state;
    rep_nxt   = rep_cnt;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          state_nxt = ST_HELD;
          rep_nxt   = '0;
        end
      end
      ST_HELD: begin
        if (!level_nxt) begin
          state_nxt = ST_IDLE;
          rep_nxt   = '0;
        end else if (rep_cnt == REP_W'(REPEAT_DELAY - 1)) begin
          state_nxt = ST_REPEAT;
          rep_nxt   = '0;
        end else begin
          rep_nxt   = rep_cnt + REP_W'(1);
        end
      end
      ST_REPEAT: begin
        if (!level_nxt) begin
          state_nxt = ST_IDLE;
          rep_nxt   = '0;
        end else if (rep_cnt == REP_W'(REPEAT_PERIOD - 1)) begin
          rep_nxt   = '0;
        end else begin
          rep_nxt   = rep_cnt + REP_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        rep_nxt   = '0;
      end
    endcase
  end

  // A release on a terminal-count edge wins over the repeat strobe.
  always_comb begin
    pulse_nxt = 1'b0;
    case (state)
      ST_IDLE:   pulse_nxt = rise;
      ST_HELD:   pulse_nxt = level_nxt && (rep_cnt == REP_W'(REPEAT_DELAY - 1));
      ST_REPEAT: pulse_nxt = level_nxt && (rep_cnt == REP_W'(REPEAT_PERIOD - 1));
      default:   pulse_nxt = 1'b0;
    endcase
  end
`else
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (rise)       state_nxt = ST_HELD;
      ST_HELD: if (!level_nxt) state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    pulse_nxt = 1'b0;
    if (state == ST_IDLE) pulse_nxt = rise;
  end
`endif

endmodule

// File: rtl/adj_button_conditioner.sv
// Conditions the three raw clock-adjust buttons into single-cycle strobes for vga_clock.
// Auto-repeat on hold is enabled by defining ADJ_AUTOREPEAT_EN.
module adj_button_conditioner
  import adj_btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] btn_raw,
  output logic [2:0] adj_pulse,
  output logic [2:0] btn_level,
  output logic       any_held
);

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    adj_btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_channel (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (btn_raw[ch]),
      .pulse   (adj_pulse[ch]),
      .level   (btn_level[ch])
    );
  end

  assign any_held = |btn_level;

endmodule

// File: tb/tb_adj_button_conditioner.sv
// Scoreboard bench for adj_button_conditioner with short debounce/repeat timing.
module tb_adj_button_conditioner;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] btn_raw = '0;
  logic [2:0] adj_pulse;
  logic [2:0] btn_level;
  logic       any_held;

  adj_button_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn_raw   (btn_raw),
    .adj_pulse (adj_pulse),
    .btn_level (btn_level),
    .any_held  (any_held)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] pulse;
    logic [2:0] level;
    logic       held;
  } exp_t;

  exp_t expq[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: raw delayed two edges, level flips after D consecutive
  // differing samples, strobes at press time t0 and (with auto-repeat) at
  // t0+RD+k*RP while the level stays high.
  int         cyc = 0;
  logic [2:0] h0 = '0;
  logic [2:0] h1 = '0;
  logic [2:0] lvl = '0;
  int         run[3] = '{0, 0, 0};
  int         t0[3]  = '{0, 0, 0};

  always @(posedge clk) begin : model
    exp_t       e;
    logic [2:0] prev;
    logic       s;
`ifdef ADJ_AUTOREPEAT_EN
    int         el;
`endif
    e = '0;
    cyc++;
    if (!reset_n) begin
      h0  = '0;
      h1  = '0;
      lvl = '0;
      for (int c = 0; c < 3; c++) run[c] = 0;
    end else begin
      prev = lvl;
      for (int c = 0; c < 3; c++) begin
        s = h1[c];
        if (s != lvl[c]) begin
          run[c]++;
          if (run[c] == D) begin
            lvl[c] = ~lvl[c];
            run[c] = 0;
          end
        end else begin
          run[c] = 0;
        end
        if (lvl[c] && !prev[c]) begin
          t0[c] = cyc;
          e.pulse[c] = 1'b1;
        end
`ifdef ADJ_AUTOREPEAT_EN
        else if (lvl[c]) begin
          el = cyc - t0[c];
          if (el >= RD && ((el - RD) % RP) == 0) e.pulse[c] = 1'b1;
        end
`endif
      end
      h1 = h0;
      h0 = btn_raw;
    end
    e.level = lvl;
    e.held  = |lvl;
    expq.push_back(e);
  end

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b (cycle %0d, t=%0t)", name, act, want, cyc, $time);
    end
  endtask

  // Monitor: one expected entry per clock; outputs must be zero while in reset.
  initial begin : monitor
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (expq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL scoreboard_empty: got no expected entry, expected one (cycle %0d)", cyc);
      end else begin
        e = expq.pop_front();
        if (!reset_n) e = '0;
        check("adj_pulse", adj_pulse, e.pulse);
        check("btn_level", btn_level, e.level);
        check("any_held", {2'b00, any_held}, {2'b00, e.held});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : stimulus
    int dur[3];
    idle(3);
    #2 reset_n = 1'b1;
    idle(3);

    // clean press on hrs
    btn_raw[0] = 1'b1;
    idle(10);
    btn_raw[0] = 1'b0;
    idle(12);

    // bounce on min, then a steady press
    for (int k = 0; k < 4; k++) begin
      btn_raw[1] = (k % 2 == 0);
      idle(2);
    end
    btn_raw[1] = 1'b1;
    idle(12);
    btn_raw[1] = 1'b0;
    idle(12);

    // long hold on sec for auto-repeat
    btn_raw[2] = 1'b1;
    idle(65);
    btn_raw[2] = 1'b0;
    idle(12);

    // release so the level falls on the third repeat edge, then press again
    btn_raw[0] = 1'b1;
    idle(36);
    btn_raw[0] = 1'b0;
    idle(12);
    btn_raw[0] = 1'b1;
    idle(10);
    btn_raw[0] = 1'b0;
    idle(12);

    // simultaneous press, asynchronous reset mid-hold, held through release
    btn_raw = 3'b111;
    idle(12);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_pulse", adj_pulse, 3'b000);
    check("async_rst_level", btn_level, 3'b000);
    check("async_rst_held", {2'b00, any_held}, 3'b000);
    idle(2);
    #2 reset_n = 1'b1;
    idle(15);
    btn_raw = 3'b000;
    idle(12);

    // random press/glitch traffic per channel
    for (int c = 0; c < 3; c++) dur[c] = 0;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        if (dur[c] == 0) begin
          btn_raw[c] = 1'($urandom_range(0, 1));
          dur[c]     = int'($urandom_range(1, 45));
        end
        dur[c]--;
      end
    end
    btn_raw = '0;
    idle(12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
